// File: rtl/adventure_controller.sv
// Sequencing controller for the adventure-game room FSM: debounced, arbitrated
// single-shot move pulses, win/death tracking, move counting and timed restart.
module adventure_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned MOVE_W          = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_n,
   input  logic              btn_s,
   input  logic              btn_e,
   input  logic              btn_w,
   input  logic              win,
   input  logic              death,
   output logic              room_n,
   output logic              room_s,
   output logic              room_e,
   output logic              room_w,
   output logic              room_reset,
   output logic [MOVE_W-1:0] move_count,
   output logic              game_over,
   output logic [1:0]        outcome
);

   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {INIT, IDLE, MOVE, RELEASE, OVER} state_t;

   // Button vectors are ordered {N, S, E, W}, which is also the arbitration order.
   logic [3:0]       raw;
   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       level;
   logic [CNT_W-1:0] db_cnt [4];

   state_t            state;
   logic [3:0]        dir;
   logic [HOLD_W-1:0] hold_cnt;
   logic              end_game;
   logic              playing;

   assign raw = {btn_n, btn_s, btn_e, btn_w};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         level <= '0;
         for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int unsigned i = 0; i < 4; i++) begin
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               level[i]  <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign end_game = win | death;
   assign playing  = (state == IDLE) || (state == MOVE) || (state == RELEASE);

   // Move is counted on entry to MOVE, so a game end seen in MOVE keeps its count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         dir        <= '0;
         game_over  <= 1'b0;
         outcome    <= 2'b00;
         move_count <= '0;
         hold_cnt   <= '0;
      end else begin
         dir <= '0;
         if (playing && end_game) begin
            state     <= OVER;
            game_over <= 1'b1;
            hold_cnt  <= HOLD_LOAD;
            outcome   <= win ? 2'b01 : 2'b10;
         end else begin
            case (state)
               INIT: begin
                  move_count <= '0;
                  outcome    <= 2'b00;
                  game_over  <= 1'b0;
                  state      <= IDLE;
               end
               IDLE: begin
                  if (|level) begin
                     state <= MOVE;
                     if (level[3])      dir <= 4'b1000;
                     else if (level[2]) dir <= 4'b0100;
                     else if (level[1]) dir <= 4'b0010;
                     else               dir <= 4'b0001;
                     if (move_count != '1) move_count <= move_count + 1'b1;
                  end
               end
               MOVE: state <= RELEASE;
               RELEASE: begin
                  if (level == '0) state <= IDLE;
               end
               OVER: begin
                  if (hold_cnt == '0) begin
                     state     <= INIT;
                     game_over <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end
               default: state <= INIT;
            endcase
         end
      end
   end

   assign room_n     = dir[3];
   assign room_s     = dir[2];
   assign room_e     = dir[1];
   assign room_w     = dir[0];
   assign room_reset = reset | (state == INIT);

endmodule
